// File: rtl/divisor_control_if.sv
// Operand, start and result bundle between the board I/O and the divider controller.
interface divisor_control_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] dividendo;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH-1:0] resultado;
   logic [WIDTH-1:0] residuo;
   logic             done;
   logic             busy;
   logic             err;

   modport master (
      output start, dividendo, divisor,
      input  resultado, residuo, done, busy, err
   );

   modport slave (
      input  start, dividendo, divisor,
      output resultado, residuo, done, busy, err
   );
endinterface

// File: rtl/divisor_control.sv
// Restoring unsigned divider: edge-triggered start, one quotient bit per
// SHIFT/SUB pair. The status/result registers are decoded from the state
// register, so they settle one clock after the state they belong to.
module divisor_control #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input logic              clk,
   input logic              rst_n,
   divisor_control_if.slave bus
);

   typedef enum logic [2:0] {IDLE, LOAD, SHIFT, SUB, DONE, ERR} state_t;

   state_t           state, state_nxt;
   logic             start_q;
   logic             accept;
   logic [WIDTH:0]   a;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] m;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] res_r;
   logic [WIDTH-1:0] rem_r;
   logic             done_r;
   logic             busy_r;
   logic             err_r;

   assign bus.resultado = res_r;
   assign bus.residuo   = rem_r;
   assign bus.done      = done_r;
   assign bus.busy      = busy_r;
   assign bus.err       = err_r;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Start edge qualification and next-state selection.
   always_comb begin
      accept    = 1'b0;
      state_nxt = state;
      case (state)
         IDLE, DONE, ERR: begin
            accept = bus.start && !start_q;
            if (accept) state_nxt = (bus.divisor == '0) ? ERR : LOAD;
         end
         LOAD:    state_nxt = SHIFT;
         SHIFT:   state_nxt = SUB;
         SUB:     state_nxt = (count == CNT_W'(1)) ? DONE : SHIFT;
         default: state_nxt = IDLE;
      endcase
   end

   // Shift-subtract datapath and start edge history.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_q <= 1'b0;
         a       <= '0;
         q       <= '0;
         m       <= '0;
         count   <= '0;
      end else begin
         start_q <= bus.start;
         case (state)
            IDLE, DONE, ERR: begin
               if (accept) begin
                  m <= bus.divisor;
                  q <= bus.dividendo;
               end
            end
            LOAD: begin
               a     <= '0;
               count <= CNT_W'(WIDTH);
            end
            SHIFT: begin
               a <= {a[WIDTH-1:0], q[WIDTH-1]};
               q <= {q[WIDTH-2:0], 1'b0};
            end
            SUB: begin
               // A is one bit wider than M so the compare/subtract cannot wrap.
               if (a >= {1'b0, m}) begin
                  a    <= a - {1'b0, m};
                  q[0] <= 1'b1;
               end else begin
                  q[0] <= 1'b0;
               end
               count <= count - CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   // Result and status registers; a fresh start always clears the old status.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_r  <= '0;
         rem_r  <= '0;
         done_r <= 1'b0;
         busy_r <= 1'b0;
         err_r  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  done_r <= 1'b0;
                  err_r  <= 1'b0;
                  busy_r <= 1'b0;
               end
            end
            LOAD: busy_r <= 1'b1;
            DONE: begin
               if (accept) begin
                  done_r <= 1'b0;
                  err_r  <= 1'b0;
                  busy_r <= 1'b0;
               end else begin
                  res_r  <= q;
                  rem_r  <= a[WIDTH-1:0];
                  done_r <= 1'b1;
                  busy_r <= 1'b0;
               end
            end
            ERR: begin
               if (accept) begin
                  done_r <= 1'b0;
                  err_r  <= 1'b0;
                  busy_r <= 1'b0;
               end else begin
                  res_r  <= '0;
                  rem_r  <= '0;
                  err_r  <= 1'b1;
                  done_r <= 1'b0;
                  busy_r <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
